// File: rtl/fact_accel_unit_if.sv
// Register-bus interface for fact_accel_unit.
//   sel : device select from the address decoder
//   A   : word offset (00=N, 01=GO, 10=STATUS, 11=RESULT)
//   WE  : write strobe, effective only together with sel
//   WD  : write data
//   RD  : combinational read data for offset A
// The bus master drives sel/A/WE/WD; the block drives RD.
interface fact_accel_unit_if;
  logic        sel;
  logic [1:0]  A;
  logic        WE;
  logic [31:0] WD;
  logic [31:0] RD;

  modport master (output sel, A, WE, WD, input RD);
  modport slave  (input sel, A, WE, WD, output RD);
endinterface

// File: rtl/fact_accel_unit.sv
// Iterative factorial accelerator behind a four-word register window.
//   clk : sole clock, rising edge
//   rst : synchronous active-high reset
//   bus : fact_accel_unit_if.slave (sel, A, WE, WD in; RD out)
// Register map:
//   00 N      (rw) operand, 4 bits; writes ignored while computing
//   01 GO     (w)  WD[0]=1 starts a run; reads back {31'b0, busy}
//   10 STATUS (r)  {30'b0, err, done}
//   11 RESULT (r)  N! for N<=12, 0 with err=1 for N>12
module fact_accel_unit (
  input  logic                    clk,
  input  logic                    rst,
  fact_accel_unit_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OFF_N      = 2'b00;
  localparam logic [1:0] OFF_GO     = 2'b01;
  localparam logic [1:0] OFF_STATUS = 2'b10;
  localparam logic [1:0] OFF_RESULT = 2'b11;

  // Largest N whose factorial fits in 32 bits.
  localparam logic [3:0] N_MAX = 4'd12;

  state_t      state_q, state_d;
  logic [3:0]  n_q, n_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] prod_q, prod_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic wr_en;
  logic wr_n;
  logic wr_go;

  // Only WD[3:0] (N) and WD[0] (GO) carry meaning; the rest is dropped.
  logic unused_wd_hi;
  assign unused_wd_hi = ^bus.WD[31:4];

  assign wr_en = bus.sel && bus.WE;
  assign wr_n  = wr_en && (bus.A == OFF_N);
  assign wr_go = wr_en && (bus.A == OFF_GO) && bus.WD[0];

  // Next-state and datapath. Every register holds by default, so no
  // branch below can leave a variable unassigned.
  // NOTE: defaults first in always_comb keep every path assigned and
  // prevent latch inference.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    result_d = result_q;
    done_d   = done_q;
    err_d    = err_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (wr_n) begin
          n_d = bus.WD[3:0];
        end
        if (wr_go) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          cnt_d   = n_q;
          prod_d  = 32'd1;
          state_d = CALC;
        end
      end

      CALC: begin
        // cnt only exceeds N_MAX on the first CALC cycle (it starts at N
        // and only counts down), so this branch is the overflow reject.
        if (cnt_q > N_MAX) begin
          err_d    = 1'b1;
          done_d   = 1'b1;
          result_d = 32'd0;
          state_d  = DONE;
        end else if (cnt_q > 4'd1) begin
          prod_d = prod_q * {28'd0, cnt_q};
          cnt_d  = cnt_q - 4'd1;
        end else begin
          result_d = prod_q;
          done_d   = 1'b1;
          state_d  = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Synchronous reset wins over any write presented in the same cycle.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      n_q      <= 4'd0;
      cnt_q    <= 4'd0;
      prod_q   <= 32'd0;
      result_q <= 32'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Read mux depends only on A and registered state, so a read and write
  // at the same offset in one cycle returns the pre-edge value.
  always_comb begin
    bus.RD = 32'd0;
    unique case (bus.A)
      OFF_N:      bus.RD = {28'd0, n_q};
      OFF_GO:     bus.RD = {31'd0, (state_q == CALC)};
      OFF_STATUS: bus.RD = {30'd0, err_q, done_q};
      OFF_RESULT: bus.RD = result_q;
      default:    bus.RD = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_fact_accel_unit.sv
// Self-checking bench for fact_accel_unit. Expected values come from a
// plain arithmetic factorial model and the documented cycle latency.
module tb_fact_accel_unit;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  fact_accel_unit_if bus ();

  fact_accel_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] fact_ref(input int n);
    logic [31:0] r;
    if (n > 12) return 32'd0;
    r = 32'd1;
    for (int i = 2; i <= n; i++) r = r * 32'(i);
    return r;
  endfunction

  function automatic int lat_ref(input int n);
    if (n > 12) return 1;
    return (n < 1) ? 1 : n;
  endfunction

  function automatic logic [31:0] status_ref(input int n);
    return (n > 12) ? 32'h3 : 32'h1;
  endfunction

  // ---------------- bus helpers ----------------
  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.sel = 1'b1;
    bus.WE  = 1'b1;
    bus.A   = a;
    bus.WD  = d;
    @(posedge clk);
    #1;
    bus.sel = 1'b0;
    bus.WE  = 1'b0;
    bus.WD  = 32'd0;
  endtask

  task automatic rd_at(input logic [1:0] a, output logic [31:0] v);
    bus.A = a;
    #1;
    v = bus.RD;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full run for one N: load, start, check busy each cycle, then result,
  // status and the DONE hold.
  task automatic run_compute(input int n, input string tag);
    logic [31:0] v;
    logic [31:0] wd;
    int          lat;
    wd = $urandom();
    wd[3:0] = 4'(n);
    do_write(2'b00, wd);
    rd_at(2'b00, v);
    checks++;
    if (v !== 32'(n)) begin
      failures++;
      $display("FAIL %s n_readback got=%0h exp=%0h", tag, v, n);
    end
    wd = $urandom() | 32'h1;
    do_write(2'b01, wd);
    rd_at(2'b01, v);
    checks++;
    if (v !== 32'h1) begin
      failures++;
      $display("FAIL %s busy_after_go got=%0h exp=1", tag, v);
    end
    rd_at(2'b10, v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL %s status_cleared got=%0h exp=0", tag, v);
    end
    lat = lat_ref(n);
    for (int k = 1; k < lat; k++) begin
      step();
      rd_at(2'b01, v);
      checks++;
      if (v !== 32'h1) begin
        failures++;
        $display("FAIL %s busy_cycle%0d got=%0h exp=1", tag, k, v);
      end
    end
    step();
    rd_at(2'b10, v);
    checks++;
    if (v !== status_ref(n)) begin
      failures++;
      $display("FAIL %s status got=%0h exp=%0h", tag, v, status_ref(n));
    end
    rd_at(2'b11, v);
    checks++;
    if (v !== fact_ref(n)) begin
      failures++;
      $display("FAIL %s result got=%0h exp=%0h", tag, v, fact_ref(n));
    end
    rd_at(2'b01, v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL %s busy_at_done got=%0h exp=0", tag, v);
    end
    step();
    step();
    rd_at(2'b10, v);
    checks++;
    if (v !== status_ref(n)) begin
      failures++;
      $display("FAIL %s status_hold got=%0h exp=%0h", tag, v, status_ref(n));
    end
    rd_at(2'b11, v);
    checks++;
    if (v !== fact_ref(n)) begin
      failures++;
      $display("FAIL %s result_hold got=%0h exp=%0h", tag, v, fact_ref(n));
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] v;
    bus.sel = 1'b0; bus.WE = 1'b0; bus.A = 2'b00; bus.WD = 32'd0;
    rst = 1'b1;
    step();
    // A write concurrent with reset must lose.
    @(negedge clk);
    bus.sel = 1'b1; bus.WE = 1'b1; bus.A = 2'b00; bus.WD = 32'h7;
    step();
    bus.sel = 1'b0; bus.WE = 1'b0;
    rst = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd_at(2'(a), v);
      checks++;
      if (v !== 32'h0) begin
        failures++;
        $display("FAIL reset_offset%0d got=%0h exp=0", a, v);
      end
    end
  endtask

  task automatic test_basic();
    run_compute(5, "n5");
  endtask

  task automatic test_small();
    run_compute(0, "n0");
    run_compute(1, "n1");
  endtask

  task automatic test_limits();
    run_compute(12, "n12");
    run_compute(13, "n13");
    run_compute(15, "n15");
  endtask

  task automatic test_calc_writes_ignored();
    logic [31:0] v;
    do_write(2'b00, 32'd5);
    do_write(2'b01, 32'd1);   // accept edge E0
    step();                   // E1
    do_write(2'b00, 32'd3);   // E2, ignored
    do_write(2'b01, 32'd1);   // E3, ignored
    rd_at(2'b00, v);
    checks++;
    if (v !== 32'd5) begin
      failures++;
      $display("FAIL calc_n_write got=%0h exp=5", v);
    end
    step();                   // E4
    rd_at(2'b01, v);
    checks++;
    if (v !== 32'h1) begin
      failures++;
      $display("FAIL calc_busy_e4 got=%0h exp=1", v);
    end
    step();                   // E5
    rd_at(2'b10, v);
    checks++;
    if (v !== 32'h1) begin
      failures++;
      $display("FAIL calc_status_e5 got=%0h exp=1", v);
    end
    rd_at(2'b11, v);
    checks++;
    if (v !== fact_ref(5)) begin
      failures++;
      $display("FAIL calc_result got=%0h exp=%0h", v, fact_ref(5));
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] v;
    do_write(2'b00, 32'd6);
    do_write(2'b01, 32'd1);
    step();
    step();
    @(negedge clk);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd_at(2'(a), v);
      checks++;
      if (v !== 32'h0) begin
        failures++;
        $display("FAIL abort_offset%0d got=%0h exp=0", a, v);
      end
    end
    run_compute(4, "after_abort");
  endtask

  task automatic test_sel_block();
    logic [31:0] v;
    @(negedge clk);
    bus.sel = 1'b0; bus.WE = 1'b1; bus.A = 2'b01; bus.WD = 32'h1;
    step();
    @(negedge clk);
    bus.A = 2'b00; bus.WD = 32'h9;
    step();
    bus.WE = 1'b0;
    rd_at(2'b01, v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL sel0_busy got=%0h exp=0", v);
    end
    rd_at(2'b00, v);
    checks++;
    if (v !== 32'h4) begin
      failures++;
      $display("FAIL sel0_n got=%0h exp=4", v);
    end
    // Writes to read-only offsets do nothing.
    do_write(2'b11, 32'hDEAD_BEEF);
    do_write(2'b10, 32'h0);
    rd_at(2'b11, v);
    checks++;
    if (v !== fact_ref(4)) begin
      failures++;
      $display("FAIL ro_result got=%0h exp=%0h", v, fact_ref(4));
    end
    rd_at(2'b10, v);
    checks++;
    if (v !== 32'h1) begin
      failures++;
      $display("FAIL ro_status got=%0h exp=1", v);
    end
    // Second GO from DONE clears STATUS at the accept edge.
    run_compute(3, "rego");
  endtask

  task automatic test_rw_same_offset();
    logic [31:0] v;
    @(negedge clk);
    bus.sel = 1'b1; bus.WE = 1'b1; bus.A = 2'b00; bus.WD = 32'h9;
    #1;
    v = bus.RD;
    checks++;
    if (v !== 32'h3) begin
      failures++;
      $display("FAIL rw_pre_edge got=%0h exp=3", v);
    end
    step();
    bus.sel = 1'b0; bus.WE = 1'b0;
    rd_at(2'b00, v);
    checks++;
    if (v !== 32'h9) begin
      failures++;
      $display("FAIL rw_post_edge got=%0h exp=9", v);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      run_compute(int'($urandom_range(15, 0)), "rand");
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    test_reset();
    test_basic();
    test_small();
    test_limits();
    test_calc_writes_ignored();
    test_reset_abort();
    test_sel_block();
    test_rw_same_offset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
